// File: rtl/autoc_ctrl_if.sv
// autoc_ctrl_if: bundles the settings bus, the correlator stream and the
// detection outputs of autoc_ctrl.
//   master : the settings-bus / DDC side (drives writes, run and magnitudes)
//   slave  : autoc_ctrl itself (drives enable, detect results and status)
// Handshake: set_stb and corr_strobe are single-cycle valid qualifiers with
// no ready; the controller accepts every cycle they are high, so a new write
// or magnitude may be presented on every clock.
interface autoc_ctrl_if #(
   parameter int MAG_WIDTH = 32
);
   logic                 set_stb;
   logic [7:0]           set_addr;
   logic [31:0]          set_data;
   logic                 run;
   logic                 corr_strobe;
   logic [MAG_WIDTH-1:0] corr_mag;
   logic                 corr_enable;
   logic                 detect;
   logic [MAG_WIDTH-1:0] detect_mag;
   logic [15:0]          detect_count;
   logic                 busy;
   logic [1:0]           state_dbg;

   modport master (
      output set_stb, set_addr, set_data, run, corr_strobe, corr_mag,
      input  corr_enable, detect, detect_mag, detect_count, busy, state_dbg
   );

   modport slave (
      input  set_stb, set_addr, set_data, run, corr_strobe, corr_mag,
      output corr_enable, detect, detect_mag, detect_count, busy, state_dbg
   );
endinterface

// File: rtl/autoc_ctrl.sv
// autoc_ctrl: sequencer and detection controller for the autocorrelator.
// Arms over the settings bus, discards SETTLE strobes while the correlator
// delay line fills, then compares each magnitude against THRESH and emits a
// one-cycle detect with the captured magnitude and a saturating count.
// Ports:
//   clk, rst : DSP clock, synchronous active-high reset
//   bus      : autoc_ctrl_if.slave (settings bus, run, corr_strobe/corr_mag
//              in; corr_enable, detect, detect_mag, detect_count, busy and
//              state_dbg out). All outputs are registered.
// Registers (BASE+0..3): CTRL {clear_count, abort, continuous, arm},
// THRESH, SETTLE[15:0], HOLDOFF[15:0].
module autoc_ctrl #(
   parameter logic [7:0] BASE      = 8'd0,
   parameter int         MAG_WIDTH = 32
) (
   input logic         clk,
   input logic         rst,
   autoc_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_SEARCH  = 2'd2,
      S_HOLDOFF = 2'd3
   } state_t;

   localparam logic [7:0] A_CTRL    = BASE;
   localparam logic [7:0] A_THRESH  = BASE + 8'd1;
   localparam logic [7:0] A_SETTLE  = BASE + 8'd2;
   localparam logic [7:0] A_HOLDOFF = BASE + 8'd3;

   state_t               state;
   logic [15:0]          cnt;
   logic [MAG_WIDTH-1:0] thresh;
   logic [15:0]          settle_len;
   logic [15:0]          holdoff_len;
   logic                 continuous;
   logic                 active;
   logic                 detect;
   logic [MAG_WIDTH-1:0] detect_mag;
   logic [15:0]          detect_count;

   logic ctrl_wr;
   logic arm_req;
   logic abort_now;
   logic clear_req;
   logic hit;

   assign ctrl_wr   = bus.set_stb && (bus.set_addr == A_CTRL);
   // Abort is a write-triggered action or run dropping; it outranks a
   // same-cycle strobe so no detect can slip out while shutting down.
   assign abort_now = (ctrl_wr && bus.set_data[2]) || !bus.run;
   assign arm_req   = ctrl_wr && bus.set_data[0] && !abort_now;
   assign clear_req = ctrl_wr && bus.set_data[3];
   assign hit       = (state == S_SEARCH) && bus.corr_strobe &&
                      (bus.corr_mag > thresh) && !abort_now;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         thresh       <= '0;
         settle_len   <= '0;
         holdoff_len  <= '0;
         continuous   <= 1'b0;
         active       <= 1'b0;
         detect       <= 1'b0;
         detect_mag   <= '0;
         detect_count <= '0;
      end else begin
         detect <= 1'b0;

         // Register writes land at the edge, so comparisons and counter
         // loads in this same cycle still see the old values.
         if (bus.set_stb && bus.set_addr == A_THRESH)  thresh      <= bus.set_data[MAG_WIDTH-1:0];
         if (bus.set_stb && bus.set_addr == A_SETTLE)  settle_len  <= bus.set_data[15:0];
         if (bus.set_stb && bus.set_addr == A_HOLDOFF) holdoff_len <= bus.set_data[15:0];
         if (ctrl_wr) continuous <= bus.set_data[1];

         // A clear coinciding with a detect leaves exactly that detect counted.
         if (clear_req)
            detect_count <= hit ? 16'd1 : 16'd0;
         else if (hit && detect_count != 16'hFFFF)
            detect_count <= detect_count + 16'd1;

         if (state != S_IDLE && abort_now) begin
            state  <= S_IDLE;
            active <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (arm_req) begin
                     active <= 1'b1;
                     if (settle_len == 16'd0) begin
                        state <= S_SEARCH;
                     end else begin
                        state <= S_SETTLE;
                        cnt   <= settle_len;
                     end
                  end
               end
               S_SETTLE, S_HOLDOFF: begin
                  // Discarded strobes, including the one that empties cnt.
                  if (bus.corr_strobe) begin
                     cnt <= cnt - 16'd1;
                     if (cnt == 16'd1) state <= S_SEARCH;
                  end
               end
               S_SEARCH: begin
                  if (hit) begin
                     detect     <= 1'b1;
                     detect_mag <= bus.corr_mag;
                     if (!continuous) begin
                        state  <= S_IDLE;
                        active <= 1'b0;
                     end else if (holdoff_len != 16'd0) begin
                        state <= S_HOLDOFF;
                        cnt   <= holdoff_len;
                     end
                  end
               end
               default: begin
                  state  <= S_IDLE;
                  active <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.corr_enable  = active;
   assign bus.busy         = active;
   assign bus.detect       = detect;
   assign bus.detect_mag   = detect_mag;
   assign bus.detect_count = detect_count;
   assign bus.state_dbg    = state;

endmodule

// File: tb/tb_autoc_ctrl.sv
// tb_autoc_ctrl: directed bench for autoc_ctrl. Strobes that must detect
// push {cycle, count, mag} into exp_q; a negedge monitor pops and compares
// whenever detect is high and flags any expected detect that never came.
module tb_autoc_ctrl;

   localparam int         MW        = 32;
   localparam int         EW        = 32 + 16 + MW;
   localparam logic [7:0] BASE      = 8'h10;
   localparam logic [7:0] A_CTRL    = BASE;
   localparam logic [7:0] A_THRESH  = BASE + 8'd1;
   localparam logic [7:0] A_SETTLE  = BASE + 8'd2;
   localparam logic [7:0] A_HOLDOFF = BASE + 8'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] model_cnt = 16'd0;
   logic [EW-1:0] exp_q[$];

   autoc_ctrl_if #(.MAG_WIDTH(MW)) bus ();

   autoc_ctrl #(.BASE(BASE), .MAG_WIDTH(MW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] data);
      bus.set_stb  = 1'b1;
      bus.set_addr = addr;
      bus.set_data = data;
      tick();
      bus.set_stb  = 1'b0;
   endtask

   // Queue the detect this strobe should cause, with the hand-chosen hit flag.
   task automatic expect_detect(input logic [MW-1:0] mag);
      if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
      exp_q.push_back({cyc + 32'd1, model_cnt, mag});
   endtask

   task automatic strobe(input logic [MW-1:0] mag, input bit exp_hit);
      bus.corr_strobe = 1'b1;
      bus.corr_mag    = mag;
      if (exp_hit) expect_detect(mag);
      tick();
      bus.corr_strobe = 1'b0;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [EW-1:0] got;
      got = {cyc, bus.detect_count, bus.detect_mag};
      if (bus.detect) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_detect: got detect at cycle %0d mag %0d, want none", cyc, bus.detect_mag);
         end else begin
            logic [EW-1:0] want;
            want = exp_q.pop_front();
            if (got !== want) begin
               n_bad++;
               $display("FAIL detect_result: got cyc %0d cnt %0h mag %0d, want cyc %0d cnt %0h mag %0d",
                        got[EW-1:EW-32], got[MW+15:MW], got[MW-1:0],
                        want[EW-1:EW-32], want[MW+15:MW], want[MW-1:0]);
            end
         end
      end else if (exp_q.size() != 0 && exp_q[0][EW-1:EW-32] <= cyc) begin
         logic [EW-1:0] lost;
         lost = exp_q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL missing_detect: got no detect at cycle %0d, want mag %0d", cyc, lost[MW-1:0]);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bus.set_stb     = 1'b0;
      bus.set_addr    = 8'd0;
      bus.set_data    = 32'd0;
      bus.run         = 1'b1;
      bus.corr_strobe = 1'b0;
      bus.corr_mag    = '0;
      repeat (3) tick();
      rst = 1'b0;
      check("rst_corr_enable", 64'(bus.corr_enable), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_detect_mag", 64'(bus.detect_mag), 64'd0);
      check("rst_detect_count", 64'(bus.detect_count), 64'd0);
      check("rst_state", 64'(bus.state_dbg), 64'd0);

      // Settle then single-shot detect.
      wr(A_THRESH, 32'd100);
      wr(A_SETTLE, 32'd4);
      wr(A_CTRL, 32'h1);
      check("arm_busy", 64'(bus.busy), 64'd1);
      check("arm_corr_enable", 64'(bus.corr_enable), 64'd1);
      check("arm_state_settle", 64'(bus.state_dbg), 64'd1);
      repeat (4) strobe(32'd500, 1'b0);
      check("settle_done_search", 64'(bus.state_dbg), 64'd2);
      strobe(32'd50, 1'b0);
      strobe(32'd101, 1'b1);
      check("single_detect_mag", 64'(bus.detect_mag), 64'd101);
      check("single_count", 64'(bus.detect_count), 64'd1);
      check("single_busy_off", 64'(bus.busy), 64'd0);
      check("single_enable_off", 64'(bus.corr_enable), 64'd0);
      tick();
      check("detect_one_cycle", 64'(bus.detect), 64'd0);

      // Equality boundary with SETTLE=0 (straight into SEARCH).
      wr(A_SETTLE, 32'd0);
      wr(A_CTRL, 32'h1);
      check("settle0_search", 64'(bus.state_dbg), 64'd2);
      strobe(32'd100, 1'b0);
      strobe(32'd101, 1'b1);
      check("eq_back_idle", 64'(bus.state_dbg), 64'd0);

      // Continuous, HOLDOFF=3: detects on strobes 1, 5, 9.
      wr(A_HOLDOFF, 32'd3);
      wr(A_CTRL, 32'h3);
      for (int i = 1; i <= 12; i++) strobe(32'd200, (i == 1) || (i == 5) || (i == 9));
      wr(A_CTRL, 32'h4);
      check("abort_busy", 64'(bus.busy), 64'd0);

      // Continuous, HOLDOFF=0: every strobe detects.
      wr(A_HOLDOFF, 32'd0);
      wr(A_CTRL, 32'h3);
      for (int i = 0; i < 5; i++) strobe(32'd200, 1'b1);
      check("cont_count", 64'(bus.detect_count), 64'd10);

      // Abort write coinciding with a qualifying strobe.
      bus.set_stb = 1'b1; bus.set_addr = A_CTRL; bus.set_data = 32'h6;
      bus.corr_strobe = 1'b1; bus.corr_mag = 32'd200;
      tick();
      bus.set_stb = 1'b0; bus.corr_strobe = 1'b0;
      check("abort_strobe_detect", 64'(bus.detect), 64'd0);
      check("abort_strobe_busy", 64'(bus.busy), 64'd0);
      check("abort_strobe_count", 64'(bus.detect_count), 64'd10);

      // run low coinciding with a qualifying strobe.
      wr(A_CTRL, 32'h3);
      bus.run = 1'b0;
      strobe(32'd200, 1'b0);
      bus.run = 1'b1;
      check("runlow_busy", 64'(bus.busy), 64'd0);
      check("runlow_count", 64'(bus.detect_count), 64'd10);

      // Arm while run low is ignored; arm+abort is ignored.
      bus.run = 1'b0;
      wr(A_CTRL, 32'h1);
      bus.run = 1'b1;
      check("arm_runlow_busy", 64'(bus.busy), 64'd0);
      wr(A_CTRL, 32'h5);
      check("arm_abort_busy", 64'(bus.busy), 64'd0);

      // Re-arm while busy does not reload the settle counter.
      wr(A_SETTLE, 32'd2);
      wr(A_CTRL, 32'h1);
      strobe(32'd150, 1'b0);
      wr(A_CTRL, 32'h1);
      check("rearm_ignored", 64'(bus.state_dbg), 64'd1);
      strobe(32'd150, 1'b0);
      check("rearm_search", 64'(bus.state_dbg), 64'd2);
      strobe(32'd150, 1'b1);
      wr(A_SETTLE, 32'd0);

      // THRESH write applies from the next cycle.
      wr(A_CTRL, 32'h1);
      bus.set_stb = 1'b1; bus.set_addr = A_THRESH; bus.set_data = 32'd300;
      strobe(32'd200, 1'b1);
      bus.set_stb = 1'b0;
      wr(A_CTRL, 32'h1);
      strobe(32'd200, 1'b0);
      strobe(32'd301, 1'b1);
      check("thresh_count", 64'(bus.detect_count), 64'd13);
      wr(A_THRESH, 32'd100);

      // Clear, then saturate the count.
      wr(A_CTRL, 32'h8);
      model_cnt = 16'd0;
      check("clear_count", 64'(bus.detect_count), 64'd0);
      wr(A_CTRL, 32'h3);
      for (int i = 0; i < 65537; i++) strobe(32'd200, 1'b1);
      check("sat_count", 64'(bus.detect_count), 64'hFFFF);

      // clear_count in the same cycle as a detect leaves count=1.
      bus.set_stb = 1'b1; bus.set_addr = A_CTRL; bus.set_data = 32'hA;
      model_cnt = 16'd0;
      strobe(32'd200, 1'b1);
      bus.set_stb = 1'b0;
      check("clear_with_detect", 64'(bus.detect_count), 64'd1);
      strobe(32'd200, 1'b1);

      // Enter HOLDOFF, then reset mid-operation.
      wr(A_HOLDOFF, 32'd3);
      strobe(32'd200, 1'b1);
      strobe(32'd200, 1'b0);
      check("in_holdoff", 64'(bus.state_dbg), 64'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_cnt = 16'd0;
      check("midrst_enable", 64'(bus.corr_enable), 64'd0);
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_detect", 64'(bus.detect), 64'd0);
      check("midrst_mag", 64'(bus.detect_mag), 64'd0);
      check("midrst_count", 64'(bus.detect_count), 64'd0);
      check("midrst_state", 64'(bus.state_dbg), 64'd0);

      // Default registers: arm goes straight to SEARCH and mag 1 detects.
      wr(A_CTRL, 32'h1);
      check("default_search", 64'(bus.state_dbg), 64'd2);
      strobe(32'd1, 1'b1);
      check("default_idle", 64'(bus.state_dbg), 64'd0);

      repeat (3) tick();
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/autoc_ctrl.md
# autoc_ctrl

Sequencer and detection controller for the DDC-fed autocorrelator. Configured over the settings bus, it gates the correlator's enable and discards the first samples while the correlator's delay line fills. It then compares each correlation magnitude against a programmable threshold and emits a detect pulse with the captured magnitude. It sits between the settings bus, the DDC output strobe domain and the correlator, on the same clock as the DSP chain.

## Interface
- BASE, 0: settings-bus base address; registers occupy BASE+0..BASE+3.
- MAG_WIDTH, 32: width of correlation magnitude.

- clk  in  1  DSP clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- set_stb  in  1  settings write strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- run  in  1  receive chain running; low forces IDLE.
- corr_strobe  in  1  corr_mag valid this cycle.
- corr_mag  in  MAG_WIDTH  unsigned correlation magnitude.
- corr_enable  out  1  drives correlator ddc_out_enable.
- detect  out  1  one-cycle detection pulse.
- detect_mag  out  MAG_WIDTH  magnitude that caused last detect; holds until next detect.
- detect_count  out  16  detections since clear; saturates at 0xFFFF.
- busy  out  1  high in any state except IDLE.

## Operation
- Registers, written when set_stb && set_addr == BASE+n:
  - BASE+0 CTRL: bit0 arm, bit1 continuous, bit2 abort, bit3 clear_count. Bits 0, 2 and 3 are write-triggered actions; only continuous is stored.
  - BASE+1 THRESH: 32 bits; the low MAG_WIDTH bits are used.
  - BASE+2 SETTLE: low 16 bits = strobes discarded after arming.
  - BASE+3 HOLDOFF: low 16 bits = strobes ignored after a detect in continuous mode.
- States: IDLE, SETTLE, SEARCH, HOLDOFF. A 16-bit down-counter cnt is shared by SETTLE and HOLDOFF.
- IDLE:
  - corr_enable=0.
  - A CTRL write with arm=1, abort=0 and run=1 enters SETTLE with cnt=SETTLE. If SETTLE=0, it enters SEARCH directly.
  - An arm while run=0 is ignored.
- SETTLE:
  - corr_enable=1.
  - Each corr_strobe decrements cnt.
  - The strobe that takes cnt 1->0 enters SEARCH. That strobe is discarded, not compared.
- SEARCH:
  - corr_enable=1.
  - On corr_strobe with corr_mag > THRESH (strict), a detect is registered: detect pulses, detect_mag is loaded, and detect_count increments (saturating).
  - After a detect: if continuous=0, go to IDLE. If continuous=1 and HOLDOFF=0, stay in SEARCH. Otherwise go to HOLDOFF with cnt=HOLDOFF.
- HOLDOFF:
  - corr_enable=1.
  - Strobes are not compared; each decrements cnt. The strobe taking cnt 1->0 returns to SEARCH.
- Abort: a CTRL write with abort=1, or run=0, in any non-IDLE state goes to IDLE next cycle. This has priority over a same-cycle qualifying strobe, so no detect is produced.
- Arm while busy (without abort): ignored. Arm and abort in the same write: abort wins and the block stays or goes IDLE.
- clear_count zeroes detect_count. If a detect occurs in the same cycle, the count becomes 1.
- A THRESH, SETTLE or HOLDOFF write takes effect for comparisons and loads from the next cycle. It does not reload a counter already running.

## Timing
- Reset values:
  - corr_enable=0, detect=0, detect_mag=0, detect_count=0, busy=0, state IDLE.
  - THRESH=0, SETTLE=0, HOLDOFF=0, continuous=0.
- All outputs are registered.
- Arm write in cycle t: corr_enable and busy are high from t+1.
- Qualifying strobe in cycle t: detect=1, updated detect_mag and updated detect_count are visible in t+1. detect is high for exactly one cycle.
- Abort or run-low in cycle t: corr_enable=0 and busy=0 from t+1.
- Back-to-back strobes, one per cycle, are fully supported with no bubbles. The minimum detect spacing in continuous mode with HOLDOFF=0 is one cycle.
- rst mid-operation returns all state, registers and outputs to their reset values on the next edge.

## Test plan
- Arm with SETTLE=4, THRESH=100, continuous=0; strobes with mag 500,500,500,500,50,101 -> no detect during the first four strobes. 50 gives no detect. 101 gives detect one cycle later with detect_mag=101 and count=1; state returns to IDLE, corr_enable=0.
- Equality boundary: THRESH=100, mag=100 -> no detect; mag=101 -> detect.
- Continuous, HOLDOFF=3, SETTLE=0, all mags 200, THRESH=100, strobe every cycle -> detect on strobes 1, 5, 9. Same stimulus with HOLDOFF=0 -> detect on every strobe.
- Drop run, or write abort, in the same cycle as a qualifying strobe -> no detect pulse, count unchanged, busy=0 next cycle. Arm with run=0 -> busy stays 0.
- Preload detect_count near saturation (0xFFFE) via repeated detects -> sticks at 0xFFFF. clear_count coinciding with a detect -> count=1.
- Assert rst during HOLDOFF -> all outputs 0 next cycle. Re-arm with default registers enters SEARCH immediately, and any mag>0 detects.
